exp_bit_stream: RTL
===================

# exp_bit_stream

Serial exponent bit transmitter for the RSA modular-exponentiation datapath. It consumes a 64-bit exponent together with its bit length, where length is the index of the most-significant set bit and 32'hFFFF_FFFF means the exponent is zero. It emits the exponent bits MSB-first, from bit `length` down to bit 0, over a valid/ready handshake to the square-and-multiply engine. It pairs with the block that produces the length from the same operand.

## Interface
- `WIDTH`, 64: exponent width in bits.
- `LEN_W`, 32: width of the length and index fields.
- `clk`  in  1: clock.
- `rstn`  in  1: reset, asynchronous, active-low.
- `start`  in  1: one-cycle request; sampled only in IDLE.
- `abort`  in  1: synchronous cancel. Returns to IDLE with no `done`.
- `exp_in`  in  WIDTH: exponent, captured on accepted `start`.
- `length_in`  in  LEN_W: MSB index, captured on accepted `start`; all-ones means a zero exponent.
- `bit_valid`  out  1: `bit_out` is presented.
- `bit_ready`  in  1: consumer accepts `bit_out` this cycle.
- `bit_out`  out  1: current exponent bit.
- `bit_last`  out  1: current bit is bit 0.
- `bit_idx`  out  LEN_W: index of the current bit.
- `busy`  out  1: high in any state except IDLE.
- `done`  out  1: one-cycle completion pulse.
- `err`  out  1: `length_in` ≥ WIDTH and not all-ones. Valid only while `done` is high.

## Operation
- **States:** IDLE, STREAM, FINISH.
- **IDLE, `start`=1:**
  - Capture `exp_in` into a shift register pre-aligned so that bit `length_in` sits at position WIDTH-1.
  - Load the counter with `length_in`.
  - If `length_in` is all-ones, go to FINISH with `err`=0. No bits are sent.
  - If `length_in` ≥ WIDTH, go to FINISH with `err`=1. No bits are sent.
  - Otherwise, go to STREAM.
- **STREAM:**
  - `bit_valid`=1.
  - `bit_out` = shift register MSB.
  - `bit_idx` = counter.
  - `bit_last` = (counter == 0).
- **Transfer:** a transfer occurs when `bit_valid` && `bit_ready`.
  - On a transfer with counter ≠ 0: shift left by 1 and decrement the counter.
  - On a transfer with counter == 0: go to FINISH.
- **Backpressure:** while `bit_ready`=0, `bit_out`, `bit_idx` and `bit_last` hold stable and `bit_valid` stays high. `bit_valid` never drops before acceptance.
- **FINISH:** `done`=1 for one cycle, then IDLE. `err` holds its captured value during this cycle and is 0 elsewhere.
- **`start` outside IDLE:** ignored. No queuing.
- **`abort`:** takes priority over a transfer in the same cycle. Next state is IDLE, `bit_valid` drops next cycle, and no `done` is raised. `abort` in IDLE is a no-op. `abort` with `start` in IDLE: `abort` wins and `start` is dropped.
- **Counter arithmetic:** unsigned LEN_W. Decrement below 0 never occurs because FINISH is entered first.

## Timing
- **Reset values:** state=IDLE; `bit_valid`=0; `bit_out`=0; `bit_last`=0; `bit_idx`=0; `busy`=0; `done`=0; `err`=0; shift register and counter cleared. Takes effect immediately on `rstn` low.
- **Normal latency:** `start` accepted at edge N gives `bit_valid` high from cycle N+1.
- **Zero-exponent / error latency:** `done` at N+1.
- **Full-rate stream:** with `bit_ready` held high, L+1 bits take L+1 cycles, where L = `length_in`. `done` follows one cycle after the last transfer, so the total is L+3 cycles from `start` to `done` falling edge.
- **Back-to-back:** a new `start` is accepted on the cycle after `done`, when the block is back in IDLE.
- **Outputs:** all outputs are registered or decoded directly from state/registers. No combinational path from `bit_ready` to any output.
- **Reset mid-stream:** asynchronous return to reset values. No `done`. The consumer must treat the partial stream as discarded.

## Structure
- **Shared RSA package:**
  - Constants `EXP_W`=64 and `LEN_W`=32.
  - `LEN_ZERO` = all-ones length marker, shared with the length producer.
  - State enum `{IDLE, STREAM, FINISH}`.
- **Sub-modules:** single module, none required. The alignment shift (`exp_in` << (WIDTH-1-`length_in`)) is one combinational expression at load time.

## Test plan
- `exp_in`=0xB, `length_in`=3, `bit_ready`=1 → bits 1,0,1,1 on cycles 1–4; `bit_idx` 3,2,1,0; `bit_last` only on cycle 4; `done` on cycle 5; `err`=0.
- Same operand, `bit_ready` toggled 0/1 each cycle → identical bit sequence; outputs stable during stall cycles; `done` after 8 stream cycles.
- `length_in`=all-ones → no `bit_valid`; `done`=1 at cycle 1; `err`=0. `length_in`=64 → `done` at cycle 1 with `err`=1.
- `exp_in`=0x8000_0000_0000_0001, `length_in`=63 → 64 bits: 1, then 62 zeros, then 1 with `bit_last`.
- `abort` or `rstn` low after 2 transfers of a 0xFF, length=7 stream → `bit_valid`=0 next cycle (immediately for reset); no `done`; a fresh `start` then streams correctly from the new MSB.
- `start` pulsed during STREAM → ignored; current stream completes unchanged.

Source files
------------

// File: rtl/exp_bit_stream_pkg.sv
// Shared RSA exponent-path definitions: operand widths, the zero-exponent
// length marker and the bit-streamer state encoding.
package exp_bit_stream_pkg;

  localparam int EXP_W = 64;
  localparam int LEN_W = 32;

  // Length producer reports a zero exponent with this all-ones marker.
  localparam logic [LEN_W-1:0] LEN_ZERO = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_t;

  function automatic logic is_zero_len(input logic [LEN_W-1:0] len);
    return (len == LEN_ZERO);
  endfunction

endpackage

// File: rtl/exp_bit_stream.sv
// Serial MSB-first exponent bit transmitter feeding the square-and-multiply
// engine over a valid/ready handshake.
module exp_bit_stream #(
  parameter int WIDTH = exp_bit_stream_pkg::EXP_W,
  parameter int LEN_W = exp_bit_stream_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] exp_in,
  input  logic [LEN_W-1:0] length_in,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             bit_out,
  output logic             bit_last,
  output logic [LEN_W-1:0] bit_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  import exp_bit_stream_pkg::*;

  localparam logic [LEN_W-1:0] TOP_IDX = LEN_W'(WIDTH - 1);
  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q;
  logic [LEN_W-1:0] cnt_q;
  logic             err_q;

  logic             load;
  logic             shift;
  logic             len_zero;
  logic             len_err;
  logic [LEN_W-1:0] shamt;
  logic [WIDTH-1:0] sreg_load;

  // Load-time alignment: bit length_in lands on the shift register MSB.
  always_comb begin
    len_zero  = (LEN_W == 32) ? is_zero_len(32'(length_in)) : (length_in == '1);
    len_err   = !len_zero && (length_in >= WIDTH_L);
    shamt     = TOP_IDX - length_in;
    sreg_load = '0;
    if (!len_zero && !len_err) sreg_load = exp_in << shamt;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          load    = 1'b1;
          state_d = (len_zero || len_err) ? FINISH : STREAM;
        end
      end
      STREAM: begin
        // abort outranks a same-cycle transfer
        if (abort) begin
          state_d = IDLE;
        end else if (bit_ready) begin
          if (cnt_q == '0) state_d = FINISH;
          else             shift   = 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        sreg_q <= sreg_load;
        cnt_q  <= length_in;
        err_q  <= len_err;
      end else if (shift) begin
        sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
        cnt_q  <= cnt_q - 1'b1;
      end
    end
  end

  // Outputs decode from state and registers only; bit_ready never reaches them.
  always_comb begin
    bit_valid = (state_q == STREAM);
    bit_out   = bit_valid & sreg_q[WIDTH-1];
    bit_idx   = bit_valid ? cnt_q : '0;
    bit_last  = bit_valid && (cnt_q == '0);
    busy      = (state_q != IDLE);
    done      = (state_q == FINISH);
    err       = done & err_q;
  end

endmodule
